// File: rtl/bcd_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer_if
// Groups the control and status signals of the BCD countdown timer.
//   load, load_val, start, pause, tick : controller -> timer
//   count, busy, done, load_err        : timer -> controller
// master: the controlling side (drives requests, observes status).
// slave : the timer itself.
// ---------------------------------------------------------------------------
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic                  tick;
  logic [4*DIGITS-1:0]   count;
  logic                  busy;
  logic                  done;
  logic                  load_err;

  modport master (
    output load, load_val, start, pause, tick,
    input  count, busy, done, load_err
  );

  modport slave (
    input  load, load_val, start, pause, tick,
    output count, busy, done, load_err
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
// Loadable DIGITS-digit BCD down-counter with an IDLE/RUN/HOLD controller.
// Ports:
//   clk  : clock, rising edge active
//   rst  : asynchronous active-high reset
//   bus  : slave side of bcd_countdown_timer_if
//          load/load_val - preset request (rejected if any digit > 9)
//          start/pause   - run control, priority load > pause > start > tick
//          tick          - one BCD decrement per cycle while running
//          count         - registered BCD value
//          busy          - high in RUN or HOLD
//          done          - one-cycle pulse when a countdown reaches zero
//          load_err      - one-cycle pulse on a rejected load
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_countdown_timer_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    count_reg, count_next;
  logic            done_reg, done_next;
  logic            load_err_reg, load_err_next;

  logic [W-1:0]      count_dec;
  logic [DIGITS-1:0] digit_ok;
  logic [DIGITS-1:0] borrow;
  logic              load_ok;
  logic              count_zero;
  logic              count_one;

  // Per-digit load validation and the BCD borrow chain. borrow[gi] means
  // every digit below gi is 0, so digit gi must give up one.
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_ok[gi] = (bus.load_val[4*gi +: 4] <= 4'd9);

      assign count_dec[4*gi +: 4] =
        !borrow[gi]                     ? count_reg[4*gi +: 4] :
        (count_reg[4*gi +: 4] == 4'd0)  ? 4'd9                 :
                                          count_reg[4*gi +: 4] - 4'd1;

      if (gi < DIGITS - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] && (count_reg[4*gi +: 4] == 4'd0);
      end
    end
  endgenerate

  assign load_ok    = &digit_ok;
  assign count_zero = (count_reg == '0);
  assign count_one  = (count_reg == W'(1));

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      done_reg     <= done_next;
      load_err_reg <= load_err_next;
    end
  end

  // Next-state logic. pause outranks start in every state, so a start
  // coinciding with pause never launches or resumes a countdown.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    done_next     = 1'b0;
    load_err_next = 1'b0;

    if (bus.load) begin
      if (load_ok) begin
        count_next = bus.load_val;
        state_next = IDLE;
      end else begin
        load_err_next = 1'b1;
      end
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (!bus.pause && bus.start && !count_zero) state_next = RUN;
        end
        RUN: begin
          if (bus.pause) begin
            state_next = HOLD;
          end else if (bus.tick) begin
            // RUN is never entered at zero and leaves on the 1->0 tick,
            // so the decrement below can never wrap.
            count_next = count_dec;
            if (count_one) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!bus.pause && bus.start) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.count    = count_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = done_reg;
  assign bus.load_err = load_err_reg;

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits in the counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 load  input  1  load request, sampled on rising edge of clk.
REQ-005 load_val  input  4*DIGITS  BCD preset; digit 0 (units) in bits [3:0].
REQ-006 start  input  1  start or resume countdown.
REQ-007 pause  input  1  suspend countdown.
REQ-008 tick  input  1  count-enable strobe; one decrement per high cycle while running.
REQ-009 count  output  4*DIGITS  current BCD value, registered.
REQ-010 busy  output  1  high while the FSM is in RUN or HOLD, registered.
REQ-011 done  output  1  one-cycle pulse on reaching zero, registered.
REQ-012 load_err  output  1  one-cycle pulse on rejected load, registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-014 Input priority SHALL be load > pause > start > tick.
REQ-015 A load with every load_val digit <= 9 SHALL set count to load_val and state to IDLE in any state, discarding any run in progress.
REQ-016 A load with any load_val digit > 9 SHALL pulse load_err for one cycle and leave count and state unchanged.
REQ-017 In IDLE, start with count != 0 SHALL enter RUN; start with count == 0 SHALL be ignored and SHALL NOT pulse done.
REQ-018 In RUN, pause SHALL enter HOLD, and a tick in the same cycle SHALL be ignored.
REQ-019 In HOLD, start without pause SHALL return to RUN, and a tick in that same cycle SHALL be ignored.
REQ-020 In HOLD and IDLE, tick SHALL have no effect.
REQ-021 In RUN, each tick SHALL decrement count by one in BCD, with the result visible on count the cycle after the sampling edge.
REQ-022 BCD decrement: digit 0 decrements; any digit at 0 becomes 9 and borrows from the next higher digit; no digit SHALL ever hold a value > 9.
REQ-023 When a RUN tick takes count from 1 to 0, the FSM SHALL enter IDLE and done SHALL be high for exactly the first cycle in which count shows 0.
REQ-024 count SHALL never decrement below zero, and there SHALL be no wrap from 0 to all-9s.
REQ-025 start while in RUN SHALL have no effect; pause while in IDLE or HOLD SHALL have no effect.
REQ-026 busy SHALL equal (state == RUN or state == HOLD).
REQ-027 done and load_err SHALL be low in every cycle not named in REQ-016 and REQ-023.

Reset
REQ-028 While rst is high, count SHALL be 0, state SHALL be IDLE, and busy, done and load_err SHALL be 0, independent of clk.
REQ-029 Reset asserted mid-run SHALL abort the countdown immediately, with no done pulse.
REQ-030 After rst deasserts, the block SHALL ignore inputs until the first rising clk edge.

Verification
REQ-031 Load 0x0012, start, 12 ticks -> count steps 0x0011, 0x0010, 0x0009 ... 0x0000; done pulses once with count=0x0000; busy falls in the same cycle.
REQ-032 Load 0x1000, start, 1 tick -> count=0x0999; busy stays 1.
REQ-033 Load 0x00A5 -> load_err=1 for one cycle; count and state unchanged. Then load 0x0000 and start -> stays IDLE, no done.
REQ-034 Load 0x0005, start, 2 ticks, pause with tick in the same cycle -> count holds 0x0003 in HOLD; ticks ignored; start -> RUN; 3 ticks -> done.
REQ-035 Load 0x0050, start, 10 ticks, assert rst mid-tick -> count=0x0000, busy=0, done never asserted.
REQ-036 RUN at count 0x0001 with load 0x0200 and tick in the same cycle -> count=0x0200, state IDLE, no done.
